// File: rtl/ptw_pkg.sv
// Shared types and widths for the page-table-walker request arbiter.
package ptw_pkg;

  localparam int VPN_W = 27;
  localparam int PTE_W = 64;
  localparam int PRV_W = 2;

  // addr + prv + store + fetch
  localparam int REQ_W = VPN_W + PRV_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [VPN_W-1:0] addr;
    logic [PRV_W-1:0] prv;
    logic             store;
    logic             fetch;
  } ptw_req_t;

endpackage

// File: rtl/ptw_rr_arb2.sv
// Combinational two-way round-robin grant. A lone requestor always wins;
// on a tie the requestor that did not win last time is chosen.
module ptw_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       winner
);

  // winner selection and one-hot grant
  always_comb begin
    winner = 1'b0;
    grant  = 2'b00;
    case (valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
    if (valid != 2'b00) begin
      grant = winner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ptw_req_arbiter.sv
// Shares one page-table walker between the ITLB (requestor 0) and the
// DTLB (requestor 1). One walk in flight at a time; invalidates seen
// while the walk is outstanding mark the returned PTE as stale.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | no walk; grant the round-robin winner combinationally
//   ST_ISSUE | registered request presented to the PTW until accepted
//   ST_WAIT  | walk in progress, waiting for the PTW response
//   ST_RESP  | one-cycle response pulse to the owning requestor
module ptw_req_arbiter
  import ptw_pkg::*;
(
  input  logic             clock,
  input  logic             reset,

  input  logic             io_requestor_0_req_valid,
  output logic             io_requestor_0_req_ready,
  input  logic [VPN_W-1:0] io_requestor_0_req_bits_addr,
  input  logic [PRV_W-1:0] io_requestor_0_req_bits_prv,
  input  logic             io_requestor_0_req_bits_store,
  input  logic             io_requestor_0_req_bits_fetch,
  output logic             io_requestor_0_resp_valid,
  output logic [PTE_W-1:0] io_requestor_0_resp_bits_pte,
  output logic             io_requestor_0_resp_bits_stale,

  input  logic             io_requestor_1_req_valid,
  output logic             io_requestor_1_req_ready,
  input  logic [VPN_W-1:0] io_requestor_1_req_bits_addr,
  input  logic [PRV_W-1:0] io_requestor_1_req_bits_prv,
  input  logic             io_requestor_1_req_bits_store,
  input  logic             io_requestor_1_req_bits_fetch,
  output logic             io_requestor_1_resp_valid,
  output logic [PTE_W-1:0] io_requestor_1_resp_bits_pte,
  output logic             io_requestor_1_resp_bits_stale,

  input  logic             io_dpath_invalidate,

  output logic             io_ptw_req_valid,
  input  logic             io_ptw_req_ready,
  output logic [VPN_W-1:0] io_ptw_req_bits_addr,
  output logic [PRV_W-1:0] io_ptw_req_bits_prv,
  output logic             io_ptw_req_bits_store,
  output logic             io_ptw_req_bits_fetch,
  input  logic             io_ptw_resp_valid,
  input  logic [PTE_W-1:0] io_ptw_resp_bits_pte,

  output logic             io_busy
);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic             stale_q, stale_d;
  ptw_req_t         req_q, req_d;
  logic [PTE_W-1:0] pte_q, pte_d;

  logic [1:0] arb_valid;
  logic [1:0] arb_grant;
  logic       arb_winner;
  ptw_req_t   req_in_0, req_in_1;

  assign arb_valid = {io_requestor_1_req_valid, io_requestor_0_req_valid};
  assign req_in_0  = '{addr:  io_requestor_0_req_bits_addr,
                       prv:   io_requestor_0_req_bits_prv,
                       store: io_requestor_0_req_bits_store,
                       fetch: io_requestor_0_req_bits_fetch};
  assign req_in_1  = '{addr:  io_requestor_1_req_bits_addr,
                       prv:   io_requestor_1_req_bits_prv,
                       store: io_requestor_1_req_bits_store,
                       fetch: io_requestor_1_req_bits_fetch};

  ptw_rr_arb2 u_arb (
    .valid      (arb_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .winner     (arb_winner)
  );

  // next-state, capture and invalidate tracking
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    stale_d      = stale_q;
    req_d        = req_q;
    pte_d        = pte_q;
    case (state_q)
      ST_IDLE: begin
        // the winner's ready is always high, so any valid is a handshake;
        // an invalidate on this same cycle belongs to the previous epoch
        if (arb_valid != 2'b00) begin
          req_d        = arb_winner ? req_in_1 : req_in_0;
          owner_d      = arb_winner;
          last_grant_d = arb_winner;
          stale_d      = 1'b0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (io_dpath_invalidate) stale_d = 1'b1;
        if (io_ptw_req_ready)    state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (io_dpath_invalidate) stale_d = 1'b1;
        if (io_ptw_resp_valid) begin
          pte_d   = io_ptw_resp_bits_pte;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      stale_q      <= 1'b0;
      req_q        <= '0;
      pte_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      stale_q      <= stale_d;
      req_q        <= req_d;
      pte_q        <= pte_d;
    end
  end

  // outputs; response data goes to both requestors, only valid is steered
  always_comb begin
    io_requestor_0_req_ready       = (state_q == ST_IDLE) && arb_grant[0];
    io_requestor_1_req_ready       = (state_q == ST_IDLE) && arb_grant[1];
    io_requestor_0_resp_valid      = (state_q == ST_RESP) && !owner_q;
    io_requestor_1_resp_valid      = (state_q == ST_RESP) &&  owner_q;
    io_requestor_0_resp_bits_pte   = pte_q;
    io_requestor_1_resp_bits_pte   = pte_q;
    io_requestor_0_resp_bits_stale = stale_q;
    io_requestor_1_resp_bits_stale = stale_q;
    io_ptw_req_valid               = (state_q == ST_ISSUE);
    io_ptw_req_bits_addr           = req_q.addr;
    io_ptw_req_bits_prv            = req_q.prv;
    io_ptw_req_bits_store          = req_q.store;
    io_ptw_req_bits_fetch          = req_q.fetch;
    io_busy                        = (state_q != ST_IDLE);
  end

  // a PTW response with no walk outstanding is dropped; flag it in simulation
  a_resp_only_in_wait : assert property (
    @(posedge clock) disable iff (reset) io_ptw_resp_valid |-> (state_q == ST_WAIT)
  );

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Self-checking bench for ptw_req_arbiter: directed scenarios plus a
// randomized run, checked against a transaction-level reference model.
module tb_ptw_req_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        r0_valid, r0_ready, r0_store, r0_fetch, r0_resp_valid, r0_resp_stale;
  logic [26:0] r0_addr;
  logic [1:0]  r0_prv;
  logic [63:0] r0_resp_pte;
  logic        r1_valid, r1_ready, r1_store, r1_fetch, r1_resp_valid, r1_resp_stale;
  logic [26:0] r1_addr;
  logic [1:0]  r1_prv;
  logic [63:0] r1_resp_pte;
  logic        inv;
  logic        ptw_req_valid, ptw_req_ready, ptw_store, ptw_fetch, ptw_resp_valid;
  logic [26:0] ptw_addr;
  logic [1:0]  ptw_prv;
  logic [63:0] ptw_resp_pte;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int model_last = 1;   // reference round-robin memory: last winner

  typedef struct {
    logic [26:0] addr;
    logic [1:0]  prv;
    logic        store;
    logic        fetch;
  } rq_t;

  always #5 clock = ~clock;

  ptw_req_arbiter dut (
    .clock                          (clock),
    .reset                          (reset),
    .io_requestor_0_req_valid       (r0_valid),
    .io_requestor_0_req_ready       (r0_ready),
    .io_requestor_0_req_bits_addr   (r0_addr),
    .io_requestor_0_req_bits_prv    (r0_prv),
    .io_requestor_0_req_bits_store  (r0_store),
    .io_requestor_0_req_bits_fetch  (r0_fetch),
    .io_requestor_0_resp_valid      (r0_resp_valid),
    .io_requestor_0_resp_bits_pte   (r0_resp_pte),
    .io_requestor_0_resp_bits_stale (r0_resp_stale),
    .io_requestor_1_req_valid       (r1_valid),
    .io_requestor_1_req_ready       (r1_ready),
    .io_requestor_1_req_bits_addr   (r1_addr),
    .io_requestor_1_req_bits_prv    (r1_prv),
    .io_requestor_1_req_bits_store  (r1_store),
    .io_requestor_1_req_bits_fetch  (r1_fetch),
    .io_requestor_1_resp_valid      (r1_resp_valid),
    .io_requestor_1_resp_bits_pte   (r1_resp_pte),
    .io_requestor_1_resp_bits_stale (r1_resp_stale),
    .io_dpath_invalidate            (inv),
    .io_ptw_req_valid               (ptw_req_valid),
    .io_ptw_req_ready               (ptw_req_ready),
    .io_ptw_req_bits_addr           (ptw_addr),
    .io_ptw_req_bits_prv            (ptw_prv),
    .io_ptw_req_bits_store          (ptw_store),
    .io_ptw_req_bits_fetch          (ptw_fetch),
    .io_ptw_resp_valid              (ptw_resp_valid),
    .io_ptw_resp_bits_pte           (ptw_resp_pte),
    .io_busy                        (busy)
  );

  // reference arbitration: a lone requestor wins, a tie goes to the other one
  function automatic int model_winner(input logic v0, input logic v1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    return 1 - model_last;
  endfunction

  task automatic idle_inputs();
    r0_valid = 0; r0_addr = '0; r0_prv = '0; r0_store = 0; r0_fetch = 0;
    r1_valid = 0; r1_addr = '0; r1_prv = '0; r1_store = 0; r1_fetch = 0;
    inv = 0; ptw_req_ready = 0; ptw_resp_valid = 0; ptw_resp_pte = '0;
  endtask

  // Drives one complete walk from IDLE and reports what the DUT did.
  // lat is the cycle (handshake = 0) on which a requestor response appears.
  task automatic run_walk(input logic v0, input logic v1, input rq_t q0, input rq_t q1,
                          input int rdly, input int wdly, input logic [63:0] pte,
                          input logic inv_hs, input logic inv_issue, input logic inv_wait,
                          output int gnt, output int lat, output int rv0, output int rv1,
                          output logic [63:0] pte_o, output logic stale_o,
                          output bit issue_ok, output int issue_cycles);
    rq_t exp_q;
    int  cyc;
    gnt = -1; lat = -1; rv0 = 0; rv1 = 0; pte_o = '0; stale_o = 1'b0;
    issue_ok = 1; issue_cycles = 0;
    r0_valid = v0; r0_addr = q0.addr; r0_prv = q0.prv; r0_store = q0.store; r0_fetch = q0.fetch;
    r1_valid = v1; r1_addr = q1.addr; r1_prv = q1.prv; r1_store = q1.store; r1_fetch = q1.fetch;
    inv = inv_hs;
    @(negedge clock);
    if (r0_ready && r1_ready) issue_ok = 0;
    if (r0_ready) gnt = 0;
    else if (r1_ready) gnt = 1;
    exp_q = (model_winner(v0, v1) == 1) ? q1 : q0;
    @(posedge clock); #1;
    r0_valid = 0; r1_valid = 0;
    inv = inv_issue;
    cyc = 1;
    for (int i = 0; i < 40; i++) begin
      ptw_req_ready = (i >= rdly);
      @(negedge clock);
      issue_cycles++;
      if (!ptw_req_valid || ptw_addr !== exp_q.addr || ptw_prv !== exp_q.prv ||
          ptw_store !== exp_q.store || ptw_fetch !== exp_q.fetch) issue_ok = 0;
      if (r0_ready || r1_ready) issue_ok = 0;
      rv0 += int'(r0_resp_valid); rv1 += int'(r1_resp_valid);
      @(posedge clock); #1;
      cyc++;
      if (i >= rdly) break;
    end
    ptw_req_ready = 0;
    inv = inv_wait;
    for (int k = 0; k <= wdly; k++) begin
      ptw_resp_valid = (k == wdly);
      ptw_resp_pte   = (k == wdly) ? pte : ~pte;
      @(negedge clock);
      if (r0_ready || r1_ready || ptw_req_valid) issue_ok = 0;
      rv0 += int'(r0_resp_valid); rv1 += int'(r1_resp_valid);
      @(posedge clock); #1;
      cyc++;
      inv = 0;
    end
    ptw_resp_valid = 0; ptw_resp_pte = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if ((r0_resp_valid || r1_resp_valid) && lat < 0) begin
        lat = cyc;
        pte_o = r0_resp_valid ? r0_resp_pte : r1_resp_pte;
        stale_o = r0_resp_valid ? r0_resp_stale : r1_resp_stale;
      end
      rv0 += int'(r0_resp_valid); rv1 += int'(r1_resp_valid);
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (ptw_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_ptw_valid got=%b want=0", ptw_req_valid); end
    n_cmp++; if ({r0_resp_valid, r1_resp_valid} !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid got=%b want=00", {r0_resp_valid, r1_resp_valid}); end
    n_cmp++; if ({r0_ready, r1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready_novalid got=%b want=00", {r0_ready, r1_ready}); end
    @(posedge clock); #1;
    reset = 0;
    model_last = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_alternation();
    rq_t a, b;
    int gnt, lat, rv0, rv1, ic, exp_w;
    logic [63:0] pte;
    logic stale;
    bit ok;
    for (int w = 0; w < 6; w++) begin
      a = '{addr: 27'h100 + 27'(w), prv: 2'd0, store: 1'b0, fetch: 1'b1};
      b = '{addr: 27'h200 + 27'(w), prv: 2'd1, store: 1'b1, fetch: 1'b0};
      exp_w = model_winner(1, 1);
      run_walk(1, 1, a, b, 0, 0, 64'hA000 + 64'(w), 0, 0, 0, gnt, lat, rv0, rv1, pte, stale, ok, ic);
      n_cmp++; if (gnt !== exp_w) begin n_err++; $display("FAIL alt_grant walk=%0d got=%0d want=%0d", w, gnt, exp_w); end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL alt_min_turnaround walk=%0d got=%0d want=3", w, lat); end
      n_cmp++; if ((exp_w == 0 ? rv0 : rv1) !== 1 || (exp_w == 0 ? rv1 : rv0) !== 0) begin
        n_err++; $display("FAIL alt_resp_owner walk=%0d got rv0=%0d rv1=%0d want owner=%0d once", w, rv0, rv1, exp_w);
      end
      n_cmp++; if (pte !== 64'hA000 + 64'(w) || !ok) begin n_err++; $display("FAIL alt_pte_issue walk=%0d got=%h ok=%0d want=%h ok=1", w, pte, ok, 64'hA000 + 64'(w)); end
      model_last = exp_w;
    end
  endtask

  task automatic test_dtlb_alone();
    rq_t a, b;
    int gnt, lat, rv0, rv1, ic;
    logic [63:0] pte;
    logic stale;
    bit ok;
    a = '{addr: 27'h0, prv: 2'd0, store: 1'b0, fetch: 1'b0};
    b = '{addr: 27'h5A5A5A5, prv: 2'd3, store: 1'b1, fetch: 1'b0};
    n_cmp++; if (model_last !== 1) begin n_err++; $display("FAIL dtlb_alone_precond got=%0d want=1", model_last); end
    run_walk(0, 1, a, b, 0, 1, 64'h1111_2222, 0, 0, 0, gnt, lat, rv0, rv1, pte, stale, ok, ic);
    n_cmp++; if (gnt !== 1) begin n_err++; $display("FAIL dtlb_alone_grant got=%0d want=1", gnt); end
    n_cmp++; if (rv1 !== 1 || rv0 !== 0 || pte !== 64'h1111_2222 || !ok) begin
      n_err++; $display("FAIL dtlb_alone_resp got rv0=%0d rv1=%0d pte=%h ok=%0d want 0/1/%h/1", rv0, rv1, pte, ok, 64'h1111_2222);
    end
    model_last = 1;
  endtask

  task automatic test_single_itlb();
    rq_t a, b;
    int gnt, lat, rv0, rv1, ic;
    logic [63:0] pte;
    logic stale;
    bit ok;
    a = '{addr: 27'h1234567, prv: 2'd1, store: 1'b0, fetch: 1'b1};
    b = '{addr: 27'h0, prv: 2'd0, store: 1'b0, fetch: 1'b0};
    run_walk(1, 0, a, b, 0, 2, 64'hABCD_0001, 0, 0, 0, gnt, lat, rv0, rv1, pte, stale, ok, ic);
    n_cmp++; if (gnt !== 0) begin n_err++; $display("FAIL itlb_grant got=%0d want=0", gnt); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL itlb_latency got=%0d want=5", lat); end
    n_cmp++; if (rv0 !== 1) begin n_err++; $display("FAIL itlb_resp_count got=%0d want=1", rv0); end
    n_cmp++; if (rv1 !== 0) begin n_err++; $display("FAIL itlb_other_resp got=%0d want=0", rv1); end
    n_cmp++; if (pte !== 64'hABCD_0001) begin n_err++; $display("FAIL itlb_pte got=%h want=%h", pte, 64'hABCD_0001); end
    n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL itlb_stale got=%b want=0", stale); end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL itlb_issue_fields got=0 want=1"); end
    model_last = 0;
  endtask

  task automatic test_stall();
    rq_t a, b;
    int gnt, lat, rv0, rv1, ic;
    logic [63:0] pte;
    logic stale;
    bit ok;
    a = '{addr: 27'h7654321, prv: 2'd2, store: 1'b0, fetch: 1'b1};
    b = '{addr: 27'h3030303, prv: 2'd1, store: 1'b1, fetch: 1'b0};
    run_walk(1, 0, a, b, 4, 0, 64'hDEAD_BEEF_0000_0042, 0, 0, 0, gnt, lat, rv0, rv1, pte, stale, ok, ic);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_valid_fields_stable got=0 want=1"); end
    n_cmp++; if (ic !== 5) begin n_err++; $display("FAIL stall_issue_cycles got=%0d want=5", ic); end
    n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL stall_latency got=%0d want=7", lat); end
    model_last = 0;
  endtask

  task automatic test_stale();
    rq_t a, b;
    int gnt, lat, rv0, rv1, ic;
    logic [63:0] pte;
    logic stale;
    bit ok;
    a = '{addr: 27'h1, prv: 2'd0, store: 1'b0, fetch: 1'b1};
    b = '{addr: 27'h2, prv: 2'd1, store: 1'b1, fetch: 1'b0};
    run_walk(0, 1, a, b, 0, 2, 64'h5555, 0, 0, 1, gnt, lat, rv0, rv1, pte, stale, ok, ic);
    n_cmp++; if (rv1 !== 1 || stale !== 1'b1) begin n_err++; $display("FAIL stale_wait got rv1=%0d stale=%b want 1/1", rv1, stale); end
    model_last = 1;
    run_walk(0, 1, a, b, 0, 1, 64'h6666, 0, 0, 0, gnt, lat, rv0, rv1, pte, stale, ok, ic);
    n_cmp++; if (rv1 !== 1 || stale !== 1'b0) begin n_err++; $display("FAIL stale_next_clear got rv1=%0d stale=%b want 1/0", rv1, stale); end
    run_walk(1, 0, a, b, 0, 1, 64'h7777, 1, 0, 0, gnt, lat, rv0, rv1, pte, stale, ok, ic);
    n_cmp++; if (rv0 !== 1 || stale !== 1'b0) begin n_err++; $display("FAIL stale_handshake_inv got rv0=%0d stale=%b want 1/0", rv0, stale); end
    run_walk(1, 0, a, b, 2, 0, 64'h8888, 0, 1, 0, gnt, lat, rv0, rv1, pte, stale, ok, ic);
    n_cmp++; if (rv0 !== 1 || stale !== 1'b1 || pte !== 64'h8888) begin n_err++; $display("FAIL stale_issue_inv got rv0=%0d stale=%b pte=%h want 1/1/8888", rv0, stale, pte); end
    model_last = 0;
  endtask

  task automatic test_reset_midwalk();
    int bad_resp, bad_busy;
    logic busy_in_wait;
    idle_inputs();
    r0_valid = 1; r0_addr = 27'h44; r0_fetch = 1;
    @(posedge clock); #1;
    r0_valid = 0; ptw_req_ready = 1;
    @(posedge clock); #1;
    ptw_req_ready = 0;
    @(negedge clock);
    busy_in_wait = busy;
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    ptw_resp_valid = 1; ptw_resp_pte = 64'hBAD;
    @(posedge clock); #1;
    reset = 0; ptw_resp_valid = 0;
    model_last = 1;
    bad_resp = 0; bad_busy = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (r0_resp_valid || r1_resp_valid) bad_resp++;
      if (busy !== 1'b0 || ptw_req_valid !== 1'b0) bad_busy++;
      @(posedge clock); #1;
    end
    n_cmp++; if (busy_in_wait !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy_wait got=%b want=1", busy_in_wait); end
    n_cmp++; if (bad_resp !== 0) begin n_err++; $display("FAIL rst_mid_no_resp got=%0d want=0", bad_resp); end
    n_cmp++; if (bad_busy !== 0) begin n_err++; $display("FAIL rst_mid_idle got=%0d want=0", bad_busy); end
  endtask

  task automatic test_random();
    rq_t a, b;
    int gnt, lat, rv0, rv1, ic, exp_w, rdly, wdly, vp;
    logic [63:0] pte_in, pte;
    logic stale, ih, ii, iw;
    bit ok;
    for (int n = 0; n < 30; n++) begin
      vp = int'($urandom_range(1, 3));
      a = '{addr: 27'($urandom), prv: 2'($urandom), store: 1'b0, fetch: 1'($urandom)};
      b = '{addr: 27'($urandom), prv: 2'($urandom), store: 1'($urandom), fetch: 1'($urandom)};
      rdly = int'($urandom_range(0, 3));
      wdly = int'($urandom_range(0, 4));
      pte_in = {$urandom, $urandom};
      ih = 1'($urandom_range(0, 3) == 0);
      ii = 1'($urandom_range(0, 3) == 0);
      iw = 1'($urandom_range(0, 3) == 0);
      exp_w = model_winner(vp[0], vp[1]);
      run_walk(vp[0], vp[1], a, b, rdly, wdly, pte_in, ih, ii, iw, gnt, lat, rv0, rv1, pte, stale, ok, ic);
      n_cmp++; if (gnt !== exp_w) begin n_err++; $display("FAIL rnd_grant n=%0d got=%0d want=%0d", n, gnt, exp_w); end
      n_cmp++; if (lat !== 3 + rdly + wdly) begin n_err++; $display("FAIL rnd_latency n=%0d got=%0d want=%0d", n, lat, 3 + rdly + wdly); end
      n_cmp++; if ((exp_w == 0 ? rv0 : rv1) !== 1 || (exp_w == 0 ? rv1 : rv0) !== 0) begin
        n_err++; $display("FAIL rnd_resp_owner n=%0d got rv0=%0d rv1=%0d want owner=%0d once", n, rv0, rv1, exp_w);
      end
      n_cmp++; if (pte !== pte_in) begin n_err++; $display("FAIL rnd_pte n=%0d got=%h want=%h", n, pte, pte_in); end
      n_cmp++; if (stale !== (ii | iw)) begin n_err++; $display("FAIL rnd_stale n=%0d got=%b want=%b", n, stale, ii | iw); end
      n_cmp++; if (!ok || ic !== rdly + 1) begin n_err++; $display("FAIL rnd_issue n=%0d got ok=%0d cycles=%0d want ok=1 cycles=%0d", n, ok, ic, rdly + 1); end
      model_last = exp_w;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_alternation();
    test_dtlb_alone();
    test_single_itlb();
    test_stall();
    test_stale();
    test_reset_midwalk();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
